mdu_hilo: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It sits beside the EX-stage ALU, accepting mult/multu/div/divu/mthi/mtlo issued from EX. It holds `busy` so the hazard unit stalls the pipeline until HI/LO are valid for a following mfhi/mflo. It replaces single-cycle `*`/`/` with a 32-iteration shift-add / restoring datapath.

---
 rtl/mdu_hilo.sv | 182 ++++++++++++++++++
 tb/tb_mdu_hilo.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit holding the architectural HI/LO registers.
// A mult/div runs one shift-add or restoring step per cycle for WIDTH cycles, then one
// sign-fix/writeback cycle. busy stalls the pipeline in the meantime; done pulses once
// HI/LO show the new result. mthi/mtlo write HI/LO directly with no busy time.
// Ports: clk, reset (sync, active-high), start/op/a/b issue from EX,
//        busy/done status, hi/lo architectural registers.
module mdu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;
    localparam logic [5:0] LAST_IT = 6'(WIDTH - 1);

    state_t state;
    state_t next_state;

    logic [5:0]       cnt;
    logic             is_div;      // latched: divide (1) or multiply (0)
    logic             sign_a;      // latched sign flags, forced 0 for unsigned ops
    logic             sign_b;
    logic             b_zero;
    logic [WIDTH-1:0] a_orig;      // original dividend, returned in HI on divide by zero
    logic [WIDTH-1:0] opnd;        // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0] acc_hi;      // product upper half / partial remainder
    logic [WIDTH-1:0] acc_lo;      // multiplier (shifting out) / dividend->quotient

    // Issue decode: op[2]==0 covers mult/multu/div/divu; op[0]==0 marks signed.
    logic             issue_md;
    logic             issue_signed;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign issue_md     = (state == S_IDLE) && start && !op[2];
    assign issue_signed = !op[0];
    // Two's-complement negate of the most negative value wraps to itself, which is
    // exactly its magnitude when read as unsigned.
    assign mag_a = (issue_signed && a[WIDTH-1]) ? -a : a;
    assign mag_b = (issue_signed && b[WIDTH-1]) ? -b : b;

    // Multiply step: add multiplicand into the upper half when the multiplier LSB is
    // set, then shift the whole 2*WIDTH accumulator right by one.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n;
    logic [WIDTH-1:0] mul_lo_n;

    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    assign mul_hi_n = mul_sum[WIDTH:1];
    assign mul_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};

    // Restoring divide step: shift remainder:dividend left, trial-subtract divisor
    // using one extra bit so the borrow shows up as the sign.
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] div_hi_n;
    logic [WIDTH-1:0] div_lo_n;

    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_ok    = !div_diff[WIDTH];
    assign div_hi_n  = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_lo_n  = {acc_lo[WIDTH-2:0], div_ok};

    // Sign correction applied at the writeback edge.
    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign prod_raw = {acc_hi, acc_lo};
    assign prod_fix = (sign_a ^ sign_b) ? -prod_raw : prod_raw;
    assign quot_fix = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
    assign rem_fix  = sign_a ? -acc_hi : acc_hi;

    // FSM state register plus registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != S_IDLE);
            done  <= (state == S_FIX);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (issue_md) next_state = S_RUN;
            S_RUN:   if (cnt == LAST_IT) next_state = S_FIX;
            S_FIX:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Iteration datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            b_zero <= 1'b0;
            a_orig <= '0;
            opnd   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
        end else if (issue_md) begin
            cnt    <= '0;
            is_div <= op[1];
            sign_a <= issue_signed && a[WIDTH-1];
            sign_b <= issue_signed && b[WIDTH-1];
            b_zero <= (b == '0);
            a_orig <= a;
            acc_hi <= '0;
            if (op[1]) begin
                opnd   <= mag_b;
                acc_lo <= mag_a;
            end else begin
                opnd   <= mag_a;
                acc_lo <= mag_b;
            end
        end else if (state == S_RUN) begin
            cnt <= cnt + 6'd1;
            if (is_div) begin
                acc_hi <= div_hi_n;
                acc_lo <= div_lo_n;
            end else begin
                acc_hi <= mul_hi_n;
                acc_lo <= mul_lo_n;
            end
        end
    end

    // Architectural HI/LO: written only by mthi/mtlo in IDLE or at the FIX edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (state == S_IDLE && start && op == OP_MTHI) begin
            hi <= a;
        end else if (state == S_IDLE && start && op == OP_MTLO) begin
            lo <= a;
        end else if (state == S_FIX) begin
            if (is_div) begin
                if (b_zero) begin
                    // Divisor zero: the datapath already yields all-ones quotient;
                    // HI reports the raw operand rather than its corrected magnitude.
                    lo <= '1;
                    hi <= a_orig;
                end else begin
                    lo <= quot_fix;
                    hi <= rem_fix;
                end
            end else begin
                hi <= prod_fix[2*WIDTH-1:WIDTH];
                lo <= prod_fix[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: table vectors, hand sequences for mthi/mtlo, ignored start and reset
// mid-run, then random mult/div/mthi/mtlo checked against an arithmetic reference.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mdu_hilo;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    mdu_hilo #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, MIPS semantics (truncating division).
    function automatic void ref_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] rh, output logic [31:0] rl);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        logic signed [63:0] sq;
        logic signed [63:0] sr;
        logic [63:0]        ux;
        logic [63:0]        uy;
        logic [63:0]        p;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'h0, x};
        uy = {32'h0, y};
        p  = '0;
        if (o == 3'd0) begin
            p = sx * sy;
            rh = p[63:32]; rl = p[31:0];
        end else if (o == 3'd1) begin
            p = ux * uy;
            rh = p[63:32]; rl = p[31:0];
        end else if (y == 32'h0) begin
            rh = x; rl = 32'hFFFF_FFFF;
        end else if (o == 3'd2) begin
            sq = sx / sy;
            sr = sx % sy;
            rh = sr[31:0]; rl = sq[31:0];
        end else begin
            p  = ux / uy;
            rl = p[31:0];
            p  = ux % uy;
            rh = p[31:0];
        end
    endfunction

    // Issue one mult/div from a falling edge; returns at the falling edge of the done
    // cycle so the next call issues back-to-back. inj>0 pulses an extra start at that
    // RUN cycle, which must be ignored.
    task automatic run_md(input string nm, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo,
                          input int inj);
        int busy_cnt = 0;
        int done_at  = 0;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0; op = 3'b111; a = $urandom; b = $urandom;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (inj != 0 && c == inj + 1) start = 1'b0;
            if (busy) busy_cnt++;
            if (c == 1) chk({nm, " hilo held"}, {hi, lo}, {m_hi, m_lo});
            if (done) begin
                done_at = c;
                break;
            end
            if (inj != 0 && c == inj) begin
                start = 1'b1; op = 3'b000; a = 32'h7; b = 32'h5;
            end
        end
        start = 1'b0;
        chk({nm, " done cycle"}, 64'(done_at), 64'd34);
        chk({nm, " busy cycles"}, 64'(busy_cnt), 64'd33);
        chk({nm, " busy after"}, {63'h0, busy}, 64'h0);
        chk({nm, " hi"}, {32'h0, hi}, {32'h0, ehi});
        chk({nm, " lo"}, {32'h0, lo}, {32'h0, elo});
        m_hi = ehi;
        m_lo = elo;
    endtask

    // mthi/mtlo or an undefined op: result visible next cycle, never busy.
    task automatic run_mt(input string nm, input logic [2:0] o, input logic [31:0] x);
        start = 1'b1; op = o; a = x; b = $urandom;
        @(posedge clk);
        #1;
        start = 1'b0; op = 3'b111;
        if (o == 3'b100) m_hi = x;
        if (o == 3'b101) m_lo = x;
        @(negedge clk);
        chk({nm, " hi"}, {32'h0, hi}, {32'h0, m_hi});
        chk({nm, " lo"}, {32'h0, lo}, {32'h0, m_lo});
        chk({nm, " busy/done"}, {62'h0, busy, done}, 64'h0);
    endtask

    vec_t vecs[9];

    initial begin
        logic [31:0] rh;
        logic [31:0] rl;
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  o;
        int          done_seen;
        int          busy_seen;

        vecs[0] = '{3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[3] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4] = '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[5] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[6] = '{3'd3, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
        vecs[7] = '{3'd2, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[8] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

        reset = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset busy/done", {62'h0, busy, done}, 64'h0);
        chk("reset hi/lo", {hi, lo}, 64'h0);

        // Table vectors, issued back-to-back.
        for (int i = 0; i < 9; i++)
            run_md($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, 0);

        // mthi/mtlo and an undefined op.
        run_mt("mthi", 3'b100, 32'h0000_1234);
        run_mt("mtlo", 3'b101, 32'hCAFE_0001);
        run_mt("undef op", 3'b110, 32'hDEAD_BEEF);

        // div 9/3 with a stray mult start at RUN cycle 5.
        run_md("div ignore start", 3'd2, 32'd9, 32'd3, 32'd0, 32'd3, 5);

        // Reset at RUN cycle 10 of a divide.
        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0; op = 3'b111;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        chk("reset mid busy", {63'h0, busy}, 64'h0);
        chk("reset mid hi/lo", {hi, lo}, 64'h0);
        done_seen = 0; busy_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) done_seen++;
            if (busy) busy_seen++;
        end
        chk("reset mid no done", 64'(done_seen), 64'h0);
        chk("reset mid no busy", 64'(busy_seen), 64'h0);
        run_md("multu after reset", 3'd1, 32'd6, 32'd7, 32'd0, 32'd42, 0);

        // Random mix against the arithmetic reference.
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 5));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'h0;
                1: y = 32'($urandom_range(1, 9));
                2: x = 32'h8000_0000;
                3: y = 32'hFFFF_FFFF;
                default: ;
            endcase
            if (o[2]) begin
                run_mt($sformatf("rnd%0d mt", i), o, x);
            end else begin
                ref_md(o, x, y, rh, rl);
                run_md($sformatf("rnd%0d op%0d %h %h", i, o, x, y), o, x, y, rh, rl, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
